// File: rtl/irrigation_sequencer_pkg.sv
// Shared state codes for the irrigation sequencer
// and the display/monitor blocks that decode state_o.
package irrigation_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    REST  = 3'd4
  } state_t;

endpackage

// File: rtl/irrigation_sequencer_phase_timer.sv
// Tick counter for one sequencer phase; done fires on
// the tick that completes limit ticks since clear.
module irrigation_sequencer_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = tick & (cnt == limit - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/irrigation_sequencer.sv
// Timed prime/run/drain/rest valve and pump sequencer
// gated by the irrigation permit.
module irrigation_sequencer
  import irrigation_sequencer_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int PRIME_TICKS   = 2,
  parameter int RUN_MAX_TICKS = 60,
  parameter int DRAIN_TICKS   = 3,
  parameter int REST_TICKS    = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         irrigation,
  input  logic         use_sprinkler,
  output logic         dripper_valve,
  output logic         sprinkler_valve,
  output logic         pump_on,
  output logic         busy,
  output logic         timeout_pulse,
  output logic [2:0]   state_o
);

  state_t           state;
  state_t           nxt;
  logic             mode;
  logic             mode_nxt;
  logic             done;
  logic             clear;
  logic             expire;
  logic             valve;
  logic [CNT_W-1:0] limit;

  always_comb begin
    limit = CNT_W'(PRIME_TICKS);
    case (state)
      RUN:     limit = CNT_W'(RUN_MAX_TICKS);
      DRAIN:   limit = CNT_W'(DRAIN_TICKS);
      REST:    limit = CNT_W'(REST_TICKS);
      default: limit = CNT_W'(PRIME_TICKS);
    endcase
  end

  irrigation_sequencer_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .tick (tick),
    .limit(limit),
    .done (done)
  );

  // Permit drop is tested before done so a coincident tick is not counted.
  always_comb begin
    nxt      = state;
    mode_nxt = mode;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        if (irrigation) begin
          nxt      = PRIME;
          mode_nxt = use_sprinkler;
        end
      end
      PRIME: begin
        if (!irrigation) nxt = REST;
        else if (done)   nxt = RUN;
      end
      RUN: begin
        if (!irrigation) begin
          nxt = DRAIN;
        end else if (done) begin
          nxt    = DRAIN;
          expire = 1'b1;
        end
      end
      DRAIN: if (done) nxt = REST;
      REST:  if (done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    clear = (nxt != state) || (state == IDLE);
    valve = (nxt == PRIME) || (nxt == RUN) || (nxt == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      mode            <= 1'b0;
      dripper_valve   <= 1'b0;
      sprinkler_valve <= 1'b0;
      pump_on         <= 1'b0;
      busy            <= 1'b0;
      timeout_pulse   <= 1'b0;
    end else begin
      state           <= nxt;
      mode            <= mode_nxt;
      dripper_valve   <= valve & ~mode_nxt;
      sprinkler_valve <= valve & mode_nxt;
      pump_on         <= (nxt == RUN);
      busy            <= (nxt != IDLE);
      timeout_pulse   <= expire;
    end
  end

  assign state_o = state;

endmodule
